// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid-stage state encoding,
// per-boundary bundle widths and small helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned IF_ID_CTRL_W  = 8;
  localparam int unsigned IF_ID_DATA_W  = 96;
  localparam int unsigned ID_EX_CTRL_W  = 16;
  localparam int unsigned ID_EX_DATA_W  = 128;
  localparam int unsigned EX_MEM_CTRL_W = 8;
  localparam int unsigned EX_MEM_DATA_W = 112;
  localparam int unsigned MEM_WB_CTRL_W = 4;
  localparam int unsigned MEM_WB_DATA_W = 76;

  function automatic logic [1:0] occ_count(
    input logic main_v,
    input logic skid_v
  );
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones.
// Updates on the falling clock edge like the rest of the stage.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Advance only while enabled and not yet saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Reusable pipeline boundary register with 2-entry skid buffer,
// global hold, deferred flush and a saturating bubble counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W              = 16,
  parameter int unsigned DATA_W              = 128,
  parameter int          CLEAR_DATA_ON_FLUSH = 1,
  parameter int unsigned CNT_W               = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic              flush_pending,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam bit CLR_DATA = (CLEAR_DATA_ON_FLUSH != 0);

  pipe_state_e       state_q;
  pipe_state_e       state_d;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;
  logic              fpend_q;
  logic              fpend_d;

  logic main_valid;
  logic skid_valid;
  logic acc;
  logic pop;
  logic bubble_en;

  // Valid bits and handshakes derive from registered state only.
  always_comb begin
    main_valid = (state_q != PS_EMPTY);
    skid_valid = (state_q == PS_FULL);
    in_ready   = !skid_valid && !hold;
    acc        = in_valid && in_ready;
    pop        = main_valid && out_ready && !hold;
    bubble_en  = !hold && !main_valid;
  end

  // Next-state: hold freezes, flush squashes, otherwise FIFO moves.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    fpend_d     = fpend_q;
    if (hold) begin
      if (flush) begin
        fpend_d = 1'b1;
      end
    end else if (flush || fpend_q) begin
      state_d     = PS_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      fpend_d     = 1'b0;
      if (CLR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (acc) begin
            state_d     = PS_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        PS_ONE: begin
          unique case (1'b1)
            acc && pop: begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
            end
            acc && !pop: begin
              state_d     = PS_FULL;
              skid_ctrl_d = in_ctrl;
              skid_data_d = in_data;
            end
            !acc && pop: begin
              state_d = PS_EMPTY;
            end
            default: begin
              state_d = PS_ONE;
            end
          endcase
        end
        PS_FULL: begin
          if (pop) begin
            state_d     = PS_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            skid_data_d = '0;
          end
        end
        default: begin
          state_d = PS_EMPTY;
        end
      endcase
    end
  end

  // State and entry registers.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PS_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      fpend_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      fpend_q     <= fpend_d;
    end
  end

  pipe_sat_counter #(
    .W (CNT_W)
  ) u_bubble (
    .clk   (clk),
    .rst   (rst),
    .en_i  (bubble_en),
    .cnt_o (bubble_cnt)
  );

  assign out_valid     = main_valid;
  assign out_ctrl      = main_valid ? main_ctrl_q : '0;
  assign out_data      = main_data_q;
  assign occupancy     = occ_count(main_valid, skid_valid);
  assign flush_pending = fpend_q;

  // Occupancy 3 would mean a corrupt state register.
  always_comb begin
    if (!rst) begin
      assert (occupancy != 2'd3);
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_pipe_skid_stage;

  logic          clk = 1'b1;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [15:0]   in_ctrl = '0;
  logic [127:0]  in_data = '0;

  logic          in_ready, out_valid, flush_pending;
  logic [15:0]   out_ctrl;
  logic [127:0]  out_data;
  logic [1:0]    occupancy;
  logic [3:0]    bubble_cnt;

  logic          in_ready2, out_valid2, flush_pending2;
  logic [15:0]   out_ctrl2;
  logic [127:0]  out_data2;
  logic [1:0]    occupancy2;
  logic [15:0]   bubble_cnt2;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0]  c;
    logic [127:0] d;
  } ent_t;

  ent_t mq[$];
  bit   m_fp;
  int   m_bub;

  localparam logic [127:0] DEAD =
    128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .CTRL_W(16), .DATA_W(128),
    .CLEAR_DATA_ON_FLUSH(1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .flush_pending(flush_pending),
    .bubble_cnt(bubble_cnt)
  );

  pipe_skid_stage #(
    .CTRL_W(16), .DATA_W(128),
    .CLEAR_DATA_ON_FLUSH(0), .CNT_W(16)
  ) dut_stale (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_ctrl(out_ctrl2), .out_data(out_data2),
    .occupancy(occupancy2), .flush_pending(flush_pending2),
    .bubble_cnt(bubble_cnt2)
  );

  // Active edge is the falling edge; sample 1 time unit later.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hold = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_ctrl = '0; in_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_init occ=%0d rdy=%0b want 0/1", occupancy, in_ready); end
    in_valid = 1; in_ctrl = 16'h0011; in_data = 128'h11;
    tick();
    in_ctrl = 16'h0022; in_data = 128'h22;
    tick();
    in_valid = 0;
    n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL reset_fill occ got=%0d want=2", occupancy); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_mid vld=%0b occ=%0d want 0/0", out_valid, occupancy); end
    n_tests++; if (in_ready !== 1'b1 || bubble_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_mid rdy=%0b bub=%0d want 1/0", in_ready, bubble_cnt); end
    n_tests++; if (out_ctrl !== 16'h0 || out_data !== 128'h0 || flush_pending !== 1'b0) begin n_fail++; $display("FAIL reset_mid ctrl=%h data=%h fp=%0b want 0", out_ctrl, out_data, flush_pending); end
    #1 rst = 1'b0;
  endtask

  task automatic test_streaming();
    idle_inputs();
    out_ready = 1; in_valid = 1;
    in_ctrl = 16'h00A5; in_data = 128'hA5;
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_ctrl !== 16'h00A5 || occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_1 vld=%0b ctrl=%h occ=%0d want 1/00a5/1", out_valid, out_ctrl, occupancy); end
    n_tests++; if (bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL stream_bub1 got=%0d want=1", bubble_cnt); end
    in_ctrl = 16'h005A; in_data = 128'h5A;
    tick();
    n_tests++; if (out_ctrl !== 16'h005A || out_data !== 128'h5A || occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_2 ctrl=%h occ=%0d want 005a/1", out_ctrl, occupancy); end
    in_valid = 0;
    tick();
    n_tests++; if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL stream_drain vld=%0b ctrl=%h bub=%0d want 0/0/1", out_valid, out_ctrl, bubble_cnt); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_c [3];
    exp_c[0] = 16'd1; exp_c[1] = 16'd2; exp_c[2] = 16'd3;
    idle_inputs();
    in_valid = 1; in_ctrl = 16'd1;
    tick();
    n_tests++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_one occ=%0d rdy=%0b want 1/1", occupancy, in_ready); end
    in_ctrl = 16'd2;
    tick();
    n_tests++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full occ=%0d rdy=%0b want 2/0", occupancy, in_ready); end
    in_ctrl = 16'd3;
    tick();
    n_tests++; if (occupancy !== 2'd2 || out_ctrl !== 16'd1) begin n_fail++; $display("FAIL bp_held occ=%0d ctrl=%h want 2/0001", occupancy, out_ctrl); end
    out_ready = 1;
    for (int i = 1; i < 3; i++) begin
      tick();
      n_tests++; if (out_ctrl !== exp_c[i] || occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_drain%0d ctrl=%h occ=%0d want %h/1", i, out_ctrl, occupancy, exp_c[i]); end
    end
    in_valid = 0;
    tick();
    n_tests++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL bp_empty vld=%0b occ=%0d want 0/0", out_valid, occupancy); end
  endtask

  task automatic test_hold_flush();
    idle_inputs();
    in_valid = 1; in_ctrl = 16'h0007; in_data = 128'h77;
    tick();
    in_ctrl = 16'h0008; in_data = 128'h88;
    tick();
    in_valid = 0; hold = 1; flush = 1;
    tick();
    flush = 0;
    n_tests++; if (flush_pending !== 1'b1 || occupancy !== 2'd2) begin n_fail++; $display("FAIL hf_pend fp=%0b occ=%0d want 1/2", flush_pending, occupancy); end
    n_tests++; if (out_ctrl !== 16'h0007 || out_data !== 128'h77 || in_ready !== 1'b0) begin n_fail++; $display("FAIL hf_intact ctrl=%h data=%h rdy=%0b", out_ctrl, out_data, in_ready); end
    tick();
    n_tests++; if (flush_pending !== 1'b1 || occupancy !== 2'd2) begin n_fail++; $display("FAIL hf_hold2 fp=%0b occ=%0d want 1/2", flush_pending, occupancy); end
    hold = 0; in_valid = 1; out_ready = 1; in_ctrl = 16'h0009; in_data = 128'h99;
    tick();
    n_tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || flush_pending !== 1'b0) begin n_fail++; $display("FAIL hf_apply occ=%0d vld=%0b fp=%0b want 0", occupancy, out_valid, flush_pending); end
    n_tests++; if (out_ctrl !== 16'h0 || out_data !== 128'h0) begin n_fail++; $display("FAIL hf_clear ctrl=%h data=%h want 0", out_ctrl, out_data); end
    in_valid = 0; out_ready = 0;
    tick();
    n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL hf_dropped occ got=%0d want=0", occupancy); end
  endtask

  task automatic test_flush_stale();
    idle_inputs();
    in_valid = 1; in_ctrl = 16'h0033; in_data = DEAD;
    tick();
    n_tests++; if (out_data2 !== DEAD || out_ctrl2 !== 16'h0033) begin n_fail++; $display("FAIL fs_load data=%h ctrl=%h", out_data2, out_ctrl2); end
    in_valid = 0; flush = 1;
    tick();
    n_tests++; if (out_valid2 !== 1'b0 || out_ctrl2 !== 16'h0 || out_data2 !== DEAD) begin n_fail++; $display("FAIL fs_stale vld=%0b ctrl=%h data=%h want 0/0/dead", out_valid2, out_ctrl2, out_data2); end
    n_tests++; if (out_data !== 128'h0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL fs_clear data=%h occ=%0d want 0/0", out_data, occupancy); end
    tick();
    flush = 0;
    n_tests++; if (occupancy !== 2'd0 || flush_pending !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL fs_empty occ=%0d fp=%0b rdy=%0b", occupancy, flush_pending, in_ready); end
  endtask

  task automatic test_saturation();
    idle_inputs();
    #1 rst = 1; #1 rst = 0;
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (bubble_cnt !== 4'd3) begin n_fail++; $display("FAIL sat_three got=%0d want=3", bubble_cnt); end
    hold = 1;
    for (int i = 0; i < 5; i++) tick();
    n_tests++; if (bubble_cnt !== 4'd3) begin n_fail++; $display("FAIL sat_hold got=%0d want=3", bubble_cnt); end
    hold = 0;
    for (int i = 0; i < 17; i++) tick();
    n_tests++; if (bubble_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_top got=%0d want=15", bubble_cnt); end
    hold = 1;
    for (int i = 0; i < 5; i++) tick();
    hold = 0;
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (bubble_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stay got=%0d want=15", bubble_cnt); end
  endtask

  task automatic test_random();
    bit   exp_rdy;
    bit   do_pop;
    bit   do_acc;
    ent_t e;
    idle_inputs();
    #1 rst = 1; #1 rst = 0;
    mq.delete(); m_fp = 0; m_bub = 0;
    for (int i = 0; i < 600; i++) begin
      hold      = ($urandom_range(0, 6) == 0);
      flush     = ($urandom_range(0, 12) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      in_ctrl   = 16'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      exp_rdy = (mq.size() < 2) && !hold;
      n_tests++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_rdy[%0d] got=%0b want=%0b", i, in_ready, exp_rdy); end
      if (!hold && mq.size() == 0 && m_bub < 15) m_bub++;
      if (hold) begin
        if (flush) m_fp = 1;
      end else if (flush || m_fp) begin
        mq.delete();
        m_fp = 0;
      end else begin
        do_pop = (mq.size() > 0) && out_ready;
        do_acc = in_valid && exp_rdy;
        if (do_pop) void'(mq.pop_front());
        if (do_acc) begin
          e.c = in_ctrl; e.d = in_data;
          mq.push_back(e);
        end
      end
      tick();
      n_tests++; if (occupancy !== 2'(mq.size()) || out_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_occ[%0d] got=%0d vld=%0b want=%0d", i, occupancy, out_valid, mq.size()); end
      n_tests++; if (flush_pending !== m_fp || bubble_cnt !== 4'(m_bub)) begin n_fail++; $display("FAIL rnd_fp_bub[%0d] fp=%0b bub=%0d want %0b/%0d", i, flush_pending, bubble_cnt, m_fp, m_bub); end
      if (mq.size() > 0) begin
        n_tests++; if (out_ctrl !== mq[0].c || out_data !== mq[0].d) begin n_fail++; $display("FAIL rnd_head[%0d] ctrl=%h want=%h data=%h want=%h", i, out_ctrl, mq[0].c, out_data, mq[0].d); end
      end else begin
        n_tests++; if (out_ctrl !== 16'h0) begin n_fail++; $display("FAIL rnd_ctrl0[%0d] got=%h want=0", i, out_ctrl); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_hold_flush();
    test_flush_stale();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Replaces per-stage hand-written boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
- Supports a global hold (cache-miss stall) and a flush (hazard/branch squash) that clears control fields.
- Adds backpressure, deferred flush under hold, an occupancy readout and a bubble counter.

Parameters:
- CTRL_W, 16, width of control bundle (WB/M/EX bits); cleared on flush.
- DATA_W, 128, width of data bundle (PC, operands, imm, instruction, register IDs).
- CLEAR_DATA_ON_FLUSH, 1, if 1 data fields are zeroed on flush; if 0 data is left stale and only valid/ctrl are cleared.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  stage clock; all registers update on the falling edge.
- rst  in  1  asynchronous active-high reset.
- hold  in  1  global freeze from cache/memory stall.
- flush  in  1  squash all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_ctrl  out  CTRL_W  head control; forced 0 when out_valid=0.
- out_data  out  DATA_W  head data.
- occupancy  out  2  number of held entries (0..2).
- flush_pending  out  1  a flush seen during hold is waiting to be applied.
- bubble_cnt  out  CNT_W  saturating count of non-hold cycles with out_valid=0.

Behaviour:
- Reset (async, any time, including mid-transfer): state EMPTY; main/skid valid=0; ctrl and data registers=0; flush_pending=0; bubble_cnt=0. Outputs: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Transfer definitions:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready & !hold.
- in_ready = !skid_valid & !hold. It is a registered-state function only, with no combinational path from out_ready.
- States: EMPTY (occupancy 0), ONE (main valid), FULL (main+skid valid).
  - EMPTY: acc -> ONE, main<=in.
  - ONE, acc&pop: stays ONE, main<=in.
  - ONE, acc&!pop: -> FULL, skid<=in.
  - ONE, !acc&pop: -> EMPTY.
  - FULL: acc is impossible. pop -> ONE, main<=skid, skid cleared.
- Ordering is strictly FIFO. Latency: 1 falling edge from acc to out_valid when EMPTY.
- Edge priority: rst > hold > flush > normal.
- hold=1:
  - All entries, the state, and the outputs are frozen.
  - bubble_cnt is not incremented.
  - If flush=1 at the same edge, set flush_pending=1 and discard nothing yet.
- hold=0 and (flush | flush_pending):
  - Both entries are invalidated and all ctrl is zeroed; data is zeroed if CLEAR_DATA_ON_FLUSH.
  - The in entry at this edge is dropped, and pop is ignored.
  - flush_pending<=0; next state EMPTY.
- A flush in EMPTY is harmless: it leaves the stage EMPTY and clears flush_pending.
- bubble_cnt: increments at each edge with hold=0 and out_valid=0. It saturates at 2^CNT_W-1 and never wraps.
- occupancy = main_valid + skid_valid. The value 3 is unreachable; assert on it in simulation.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding: PS_EMPTY=2'd0, PS_ONE=2'd1, PS_FULL=2'd2.
  - per-stage CTRL_W/DATA_W constants (e.g. ID_EX_CTRL_W, ID_EX_DATA_W) so that stage wrappers stay consistent.
- One natural sub-module: pipe_sat_counter, a parametrised saturating counter with enable and async reset, used for bubble_cnt.
- The skid datapath stays inline.

Test Plan:
- Reset: assert rst mid-cycle with occupancy=2 -> immediately out_valid=0, occupancy=0, in_ready=1, bubble_cnt=0, out_ctrl=0.
- Streaming: in_valid=1 with ctrl=16'h00A5 then 16'h005A, out_ready=1 -> out_ctrl shows A5 then 5A on consecutive edges with 1-edge latency; occupancy stays 1; bubble_cnt stays unchanged after the first edge.
- Backpressure: out_ready=0 while 3 entries are offered (ctrl 1,2,3) -> occupancy 1 then 2, in_ready drops after the 2nd, entry 3 is held upstream. Then out_ready=1 -> outputs 1,2,3 in order with no loss or duplication.
- Hold+flush: occupancy=2, hold=1 and flush pulses 1 cycle -> flush_pending=1 and the entries are intact. Release hold -> next edge occupancy=0, out_ctrl=0, out_data=0 (CLEAR_DATA_ON_FLUSH=1), flush_pending=0.
- Flush with CLEAR_DATA_ON_FLUSH=0: flush with data=128'hDEAD... -> out_valid=0, out_ctrl=0, and the internal data register retains DEAD....
- Saturation: CNT_W=4, idle with hold=0 for 20 edges -> bubble_cnt=15 and stays 15. With hold=1 for 5 idle edges -> no change.
